// File: rtl/leap_pkg.sv
// Shared definitions for the leap accumulator arbiter.
// Holds the op encodings and the sequencer state type.
package leap_pkg;

  localparam logic [1:0] OP_DBL  = 2'b00;
  localparam logic [1:0] OP_HALF = 2'b01;
  localparam logic [1:0] OP_SUB3 = 2'b10;
  localparam logic [1:0] OP_ADD3 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/leap_dp.sv
// Leap datapath: one WIDTH-bit accumulator that applies a single op on each
// enabled step. All arithmetic wraps modulo 2^WIDTH.
module leap_dp
  import leap_pkg::*;
#(
  parameter int          WIDTH = 128,
  parameter int unsigned INIT  = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] acc_d, acc_q;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    acc_d = acc_q;
    if (step) begin
      unique case (op)
        OP_DBL:  acc_d = acc_q + acc_q;
        OP_HALF: acc_d = acc_q + (acc_q >> 1);
        OP_SUB3: acc_d = acc_q - WIDTH'(3);
        OP_ADD3: acc_d = acc_q + WIDTH'(3);
        default: acc_d = acc_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) acc_q <= WIDTH'(INIT);
    else      acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/leap_arbiter.sv
// Round-robin job arbiter in front of the leap datapath: grants one requester
// at a time, steps the accumulator for the job's count, then pulses done.
module leap_arbiter
  import leap_pkg::*;
#(
  parameter int          NREQ  = 4,
  parameter int          WIDTH = 128,
  parameter int unsigned INIT  = 17,
  parameter int          CNTW  = 4,
  localparam int         IDW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [CNTW*NREQ-1:0] req_cnt,
  output logic [NREQ-1:0]      req_ready,
  output logic                 busy,
  output logic                 done_valid,
  output logic [IDW-1:0]       done_id,
  output logic [WIDTH-1:0]     acc
);

  state_e          state_d, state_q;
  logic [IDW-1:0]  rr_ptr_d, rr_ptr_q;
  logic [IDW-1:0]  id_d, id_q;
  logic [1:0]      op_d, op_q;
  logic [CNTW-1:0] cnt_d, cnt_q;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  scan_idx;
  logic [1:0]      grant_op;
  logic [CNTW-1:0] grant_cnt;

  // Scan starts one past the last winner, so the previous grantee has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    grant_op  = '0;
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        grant_op  = req_op[2*i +: 2];
        grant_cnt = req_cnt[CNTW*i +: CNTW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_found && rst) begin
          req_ready[grant_idx] = 1'b1;
          rr_ptr_d = grant_idx;
          id_d     = grant_idx;
          op_d     = grant_op;
          cnt_d    = grant_cnt;
          state_d  = (grant_cnt == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDW'(NREQ - 1);
      id_q     <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done_valid = (state_q == DONE);
  assign done_id    = id_q;

  leap_dp #(
    .WIDTH(WIDTH),
    .INIT (INIT)
  ) u_dp (
    .clk (clk),
    .rst (rst),
    .step(state_q == RUN),
    .op  (op_q),
    .acc (acc)
  );

endmodule

// File: tb/tb_leap_arbiter.sv
// Directed bench for leap_arbiter: job sequencing, wrap-around arithmetic,
// round-robin order, zero-count jobs and reset during a running job.
module tb_leap_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 128;
  localparam int CNTW  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [2*NREQ-1:0]  req_op;
  logic [CNTW*NREQ-1:0] req_cnt;
  logic [NREQ-1:0]    req_ready;
  logic               busy;
  logic               done_valid;
  logic [1:0]         done_id;
  logic [WIDTH-1:0]   acc;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] model;

  leap_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .INIT (17),
    .CNTW (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_cnt   (req_cnt),
    .req_ready (req_ready),
    .busy      (busy),
    .done_valid(done_valid),
    .done_id   (done_id),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] leap_ref(input logic [WIDTH-1:0] a, input logic [1:0] op);
    case (op)
      2'b00:   return a + a;
      2'b01:   return a + (a >> 1);
      2'b10:   return a - 128'd3;
      default: return a + 128'd3;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_cnt   = '0;
    tick();
    tick();
    rst   = 1'b1;
    model = 128'd17;
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input int cnt);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_op[2*id +: 2] = op;
    req_cnt[CNTW*id +: CNTW] = CNTW'(cnt);
  endtask

  task automatic run_job(input string name, input int id, input logic [1:0] op,
                         input int cnt, input logic [WIDTH-1:0] exp_final);
    logic [NREQ-1:0] oh;
    oh = 4'b0001 << id;
    set_req(id, op, cnt);
    #1;
    check({name, "_ready"}, 128'(req_ready), 128'(oh));
    tick();
    req_valid = '0;
    check({name, "_busy"}, 128'(busy), 128'd1);
    check({name, "_acc_accept"}, acc, model);
    for (int i = 0; i < cnt; i++) begin
      check({name, "_run_nodone"}, 128'(done_valid), 128'd0);
      tick();
      model = leap_ref(model, op);
      check({name, "_acc_step"}, acc, model);
    end
    check({name, "_done"}, 128'(done_valid), 128'd1);
    check({name, "_done_id"}, 128'(done_id), 128'(id));
    check({name, "_acc_final"}, acc, exp_final);
    tick();
    check({name, "_done_drop"}, 128'(done_valid), 128'd0);
    check({name, "_idle"}, 128'(busy), 128'd0);
    check({name, "_acc_hold"}, acc, exp_final);
    model = exp_final;
  endtask

  logic [NREQ-1:0] rr_order [5];
  int              rr_ids   [5];

  initial begin
    rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_ids   = '{0, 1, 2, 3, 0};

    // Reset state, then the +3 chain and the x1.5 / double chain.
    do_reset();
    check("rst_acc", acc, 128'd17);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done_valid), 128'd0);
    check("rst_done_id", 128'(done_id), 128'd0);
    check("rst_ready", 128'(req_ready), 128'd0);
    run_job("add3x5", 0, 2'b11, 5, 128'h20);
    run_job("half1", 0, 2'b01, 1, 128'h30);
    run_job("dbl3", 1, 2'b00, 3, 128'h180);
    run_job("cnt0", 3, 2'b00, 0, 128'h180);

    // Wrap below zero, doubling overflow, wrap above, odd truncation.
    do_reset();
    run_job("sub3x6", 2, 2'b10, 6, {128{1'b1}});
    run_job("dbl_wrap", 3, 2'b00, 1, {{127{1'b1}}, 1'b0});
    run_job("add_wrap", 1, 2'b11, 2, 128'd4);
    run_job("half_even", 0, 2'b01, 1, 128'd6);
    run_job("add3_odd", 0, 2'b11, 1, 128'd9);
    run_job("half_odd", 2, 2'b01, 1, 128'd13);

    // All requesters held valid: grants rotate 0,1,2,3,0.
    do_reset();
    req_valid = 4'hF;
    req_op    = 8'hFF;
    req_cnt   = 16'h1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_ready", 128'(req_ready), 128'(rr_order[k]));
      tick();
      check("rr_ready_run", 128'(req_ready), 128'd0);
      tick();
      check("rr_done", 128'(done_valid), 128'd1);
      check("rr_done_id", 128'(done_id), 128'(rr_ids[k]));
      check("rr_acc", acc, 128'(17 + 3 * (k + 1)));
      tick();
    end
    req_valid = '0;

    // Reset in the middle of a 10-op job drops it and restores priority to 0.
    do_reset();
    set_req(0, 2'b11, 10);
    #1;
    tick();
    req_valid = '0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_acc", acc, 128'h1d);
    check("mid_busy", 128'(busy), 128'd1);
    rst = 1'b0;
    req_valid = 4'b0011;
    req_op[3:0] = 4'b1111;
    req_cnt[7:0] = 8'h11;
    tick();
    check("rrst_acc", acc, 128'd17);
    check("rrst_busy", 128'(busy), 128'd0);
    check("rrst_done", 128'(done_valid), 128'd0);
    check("rrst_ready", 128'(req_ready), 128'd0);
    rst = 1'b1;
    #1;
    check("rrst_grant0", 128'(req_ready), 128'b0001);
    req_valid = '0;
    tick();
    check("rrst_nodone", 128'(done_valid), 128'd0);
    check("rrst_idle", 128'(busy), 128'd0);
    check("rrst_acc_hold", acc, 128'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
